// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: control/load bus and divided-clock outputs of the divider bank
interface clk_div_bank_if #(
  parameter int NCH = 3,
  parameter int CW = 32
);
  logic [NCH-1:0] ch_en;
  logic           sync_clr;
  logic           load;
  logic [3:0]     load_ch;
  logic [CW-1:0]  load_val;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] rise;
  modport master (output ch_en, sync_clr, load, load_ch, load_val, input clk_out, tick, rise);
  modport slave (input ch_en, sync_clr, load, load_ch, load_val, output clk_out, tick, rise);
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank: NCH independent programmable square-wave dividers with shadowed divisors
module clk_div_bank #(
  parameter int NCH = 3,
  parameter int CW = 32,
  parameter logic [NCH*CW-1:0] DIV_INIT = {32'd5000000, 32'd2500, 32'd25000000}
) (
  input logic clk_in,
  input logic reset,
  clk_div_bank_if.slave bus
);
  logic [CW-1:0]  r_cnt [NCH];
  logic [CW-1:0]  r_act [NCH];
  logic [CW-1:0]  r_shd [NCH];
  logic [NCH-1:0] r_out, r_tick, r_rise;
  logic [NCH-1:0] w_ld;
  logic [CW-1:0]  w_nact [NCH];
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_ld[i] = bus.load && (bus.load_ch == 4'(i));
      w_nact[i] = w_ld[i] ? bus.load_val : r_shd[i];
    end
  end
  // act only moves at a wrap, clear or while idle, so a half-period in flight keeps its length
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        r_cnt[i] <= '0;
        r_act[i] <= DIV_INIT[i*CW +: CW];
        r_shd[i] <= DIV_INIT[i*CW +: CW];
        r_out[i] <= 1'b0;
        r_tick[i] <= 1'b0;
        r_rise[i] <= 1'b0;
      end else begin
        if (w_ld[i]) r_shd[i] <= bus.load_val;
        if (bus.sync_clr || !bus.ch_en[i]) begin
          r_cnt[i] <= '0;
          r_act[i] <= w_nact[i];
          r_out[i] <= 1'b0;
          r_tick[i] <= 1'b0;
          r_rise[i] <= 1'b0;
        end else if (r_cnt[i] >= r_act[i]) begin
          r_cnt[i] <= '0;
          r_act[i] <= w_nact[i];
          r_out[i] <= ~r_out[i];
          r_tick[i] <= 1'b1;
          r_rise[i] <= ~r_out[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
          r_tick[i] <= 1'b0;
          r_rise[i] <= 1'b0;
        end
      end
    end
  end
  assign bus.clk_out = r_out;
  assign bus.tick = r_tick;
  assign bus.rise = r_rise;
endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 The block SHALL provide parameter NCH, default 3, giving the number of independent divider channels (1..16).
REQ-002 The block SHALL provide parameter CW, default 32, giving the counter and divisor width in bits.
REQ-003 The block SHALL provide parameter DIV_INIT, default {32'd5000000, 32'd2500, 32'd25000000}, a packed NCH*CW vector of per-channel reset divisors; channel 0 occupies bits [CW-1:0].
REQ-004 Port clk_in  input  1  is the single clock; all logic is on its rising edge.
REQ-005 Port reset  input  1  is a synchronous, active-high reset.
REQ-006 Port ch_en  input  NCH  is the per-channel run enable; bit i enables channel i.
REQ-007 Port sync_clr  input  1  is a single-cycle request to phase-align all channels.
REQ-008 Port load  input  1  is the divisor write strobe.
REQ-009 Port load_ch  input  4  is the channel index for the divisor write.
REQ-010 Port load_val  input  CW  is the divisor value for the write.
REQ-011 Port clk_out  output  NCH  is the registered divided square wave per channel.
REQ-012 Port tick  output  NCH  is a registered one-cycle pulse on every clk_out toggle.
REQ-013 Port rise  output  NCH  is a registered one-cycle pulse on every clk_out 0->1 toggle only.

Function
REQ-014 Each channel SHALL hold a CW-bit counter cnt, an active divisor act, and a shadow divisor shd.
REQ-015 When a channel is enabled and cnt >= act: cnt SHALL go to 0, clk_out SHALL toggle, and tick SHALL be 1 in that same registered update; otherwise cnt SHALL increment by 1 and tick SHALL be 0.
REQ-016 rise SHALL equal tick AND the new clk_out value being 1.
REQ-017 The clk_out period SHALL be 2*(act+1) clk_in cycles; act=0 SHALL give clk_in/2 with tick high every cycle.
REQ-018 The counter SHALL never wrap through 2^CW; the >= compare guarantees termination for any act.
REQ-019 load=1 with load_ch < NCH SHALL write load_val into shd[load_ch] on that edge.
REQ-020 load=1 with load_ch >= NCH SHALL be ignored and SHALL change no state.
REQ-021 At every wrap (REQ-015), act SHALL take shd; act SHALL take load_val directly if a load to the same channel occurs in that cycle.
REQ-022 A divisor change SHALL never alter the current half-period in progress.
REQ-023 While ch_en[i]=0: cnt SHALL be held at 0, clk_out[i], tick[i], and rise[i] SHALL be 0, and act SHALL continuously take shd, with load bypass as in REQ-021.
REQ-024 On a 0->1 transition of ch_en[i], counting SHALL start from 0, and the first toggle (0->1, with rise) SHALL occur act+1 cycles after the first enabled edge.
REQ-025 sync_clr=1 SHALL, on that edge, set cnt=0 and clk_out=0 for every channel, load act from shd with load bypass, and force tick=0 and rise=0.
REQ-026 sync_clr SHALL take priority over a simultaneous wrap.
REQ-027 Channels SHALL be fully independent except for sync_clr and the shared load bus.
REQ-028 Outputs SHALL be glitch-free registers; no output SHALL be driven combinationally from inputs.

Reset
REQ-029 reset=1 SHALL, on the clock edge, set every cnt=0, clk_out=0, tick=0, and rise=0.
REQ-030 reset=1 SHALL set act[i] and shd[i] to DIV_INIT[i].
REQ-031 reset SHALL take priority over sync_clr, load, and ch_en.
REQ-032 reset asserted mid-half-period SHALL abandon that period with no trailing tick.
REQ-033 After reset deasserts, enabled channels SHALL behave as in REQ-024.

Verification
REQ-034 Basic divide: NCH=3, CW=8, DIV_INIT={8'd4,8'd1,8'd0}, ch_en=3'b111 after reset -> ch0 toggles every cycle, ch1 every 2 cycles, ch2 every 5 cycles; rise on ch2 first occurs at cycle 5.
REQ-035 Shadow load: ch2 act=4 at cnt=1, load ch2 with 9 -> the current half-period still ends at cnt=4, and the next half-periods are 10 cycles.
REQ-036 Load on wrap: load ch1 with 3 in the exact cycle ch1 wraps -> the very next half-period is 4 cycles; load_ch=5 -> no register changes.
REQ-037 Enable/sync: disable ch2 for 7 cycles, then re-enable -> clk_out[2]=0 while disabled, with first rise 5 cycles after enable; sync_clr mid-run -> all clk_out=0 and cnt=0 on the next edge, with no tick in that cycle.
REQ-038 Reset mid-operation: assert reset at ch2 cnt=3 with clk_out=1 after act was loaded to 9 -> all outputs 0, act[2]=4 (DIV_INIT) restored, and no tick is emitted.
REQ-039 Edge width: CW=4, act=15 -> half-period is 16 cycles, and cnt never exceeds 15.
